// File: rtl/alu_pkg.sv
// Shared definitions for the multi-cycle ALU: operation encodings and FSM states.
package alu_pkg;

    // Operation select encodings
    localparam logic [3:0] SEL_AND   = 4'b0000;
    localparam logic [3:0] SEL_OR    = 4'b0001;
    localparam logic [3:0] SEL_ADD   = 4'b0010;
    localparam logic [3:0] SEL_XOR   = 4'b0011;
    localparam logic [3:0] SEL_SUB   = 4'b0110;
    localparam logic [3:0] SEL_SLTU  = 4'b0111;
    localparam logic [3:0] SEL_MULTU = 4'b1000;
    localparam logic [3:0] SEL_DIVU  = 4'b1001;
    localparam logic [3:0] SEL_MFHI  = 4'b1010;
    localparam logic [3:0] SEL_MFLO  = 4'b1011;
    localparam logic [3:0] SEL_NOR   = 4'b1100;
    localparam logic [3:0] SEL_SLT   = 4'b1101;

    // Control FSM states
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2,
        S_FIN  = 2'd3
    } state_t;

endpackage

// File: rtl/alu_md_iter.sv
// Iterative multiply/divide datapath: one shift-add or restoring-divide step per cycle.
// {acc_hi, acc_lo} is the product register for MULTU and the {remainder, quotient}
// register for DIVU. opb holds the multiplicand or the divisor.
module alu_md_iter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             mode_div,
    input  logic             step,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] acc_lo,
    output logic [WIDTH-1:0] nxt_hi,
    output logic [WIDTH-1:0] nxt_lo,
    output logic             last
);

    localparam int CW = $clog2(WIDTH + 1);

    logic [WIDTH-1:0] acc_hi;
    logic [WIDTH-1:0] opb;
    logic             is_div;
    logic [CW-1:0]    cnt;
    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   trial;

    // Next accumulator value for one iteration of the selected algorithm
    always_comb begin
        sum    = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opb} : {(WIDTH+1){1'b0}});
        trial  = {acc_hi, acc_lo[WIDTH-1]} - {1'b0, opb};
        nxt_hi = sum[WIDTH:1];
        nxt_lo = {sum[0], acc_lo[WIDTH-1:1]};
        if (is_div) begin
            if (!trial[WIDTH]) begin
                // Trial subtraction fits: keep it and shift in a 1 quotient bit
                nxt_hi = trial[WIDTH-1:0];
                nxt_lo = {acc_lo[WIDTH-2:0], 1'b1};
            end else begin
                // Borrow: restore the shifted remainder and shift in a 0
                nxt_hi = {acc_hi[WIDTH-2:0], acc_lo[WIDTH-1]};
                nxt_lo = {acc_lo[WIDTH-2:0], 1'b0};
            end
        end
        last = (cnt == CW'(WIDTH - 1));
    end

    // Operand load and per-cycle accumulator/counter update
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_hi <= '0;
            acc_lo <= '0;
            opb    <= '0;
            is_div <= 1'b0;
            cnt    <= '0;
        end else if (load) begin
            acc_hi <= '0;
            acc_lo <= mode_div ? a : b;
            opb    <= mode_div ? b : a;
            is_div <= mode_div;
            cnt    <= '0;
        end else if (step) begin
            acc_hi <= nxt_hi;
            acc_lo <= nxt_lo;
            cnt    <= cnt + CW'(1);
        end
    end

endmodule

// File: rtl/alu_md.sv
// Multi-cycle ALU with single-cycle logic/arithmetic ops and iterative MULTU/DIVU
// writing the architectural HI/LO registers.
// Handshake: start is accepted on a rising edge when busy=0; done pulses for one
// cycle with res/zf/hi/lo valid, and start may be accepted in that same cycle.
module alu_md
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] op1,
    input  logic [WIDTH-1:0] op2,
    input  logic [3:0]       sel,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] res,
    output logic             zf,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output state_t           fsm_state
);

    state_t           state;
    logic             accept;
    logic             is_long;
    logic [WIDTH-1:0] alu_res;
    logic [WIDTH-1:0] iter_acc_lo;
    logic [WIDTH-1:0] iter_hi;
    logic [WIDTH-1:0] iter_lo;
    logic             iter_last;

    assign fsm_state = state;
    assign accept    = start && !busy;
    assign is_long   = (sel == SEL_MULTU) || (sel == SEL_DIVU);

    alu_md_iter #(.WIDTH(WIDTH)) u_iter (
        .clk      (clk),
        .rst      (rst),
        .load     (accept && is_long),
        .mode_div (sel == SEL_DIVU),
        .step     ((state == S_MUL) || (state == S_DIV)),
        .a        (op1),
        .b        (op2),
        .acc_lo   (iter_acc_lo),
        .nxt_hi   (iter_hi),
        .nxt_lo   (iter_lo),
        .last     (iter_last)
    );

    // Single-cycle result decode; MFHI/MFLO read the HI/LO values current now
    always_comb begin
        alu_res = '0;
        case (sel)
            SEL_AND:  alu_res = op1 & op2;
            SEL_OR:   alu_res = op1 | op2;
            SEL_XOR:  alu_res = op1 ^ op2;
            SEL_NOR:  alu_res = ~(op1 | op2);
            SEL_ADD:  alu_res = op1 + op2;
            SEL_SUB:  alu_res = op1 - op2;
            SEL_SLTU: alu_res = {{(WIDTH-1){1'b0}}, (op1 < op2)};
            SEL_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(op1) < $signed(op2))};
            SEL_MFHI: alu_res = hi;
            SEL_MFLO: alu_res = lo;
            default:  alu_res = '0;
        endcase
    end

    // Control FSM with registered busy/done/result/flag and HI/LO writeback.
    // FIN serves two roles: entered from MUL/DIV it is the done cycle (busy=0,
    // new requests accepted); entered on DIVU by zero it is a writeback cycle
    // (busy=1) that produces the result one cycle later.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
            res   <= '0;
            zf    <= 1'b1;
            hi    <= '0;
            lo    <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                S_MUL, S_DIV: begin
                    if (iter_last) begin
                        hi    <= iter_hi;
                        lo    <= iter_lo;
                        res   <= iter_lo;
                        zf    <= (state == S_MUL) ? ({iter_hi, iter_lo} == '0)
                                                  : (iter_lo == '0);
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= S_FIN;
                    end
                end
                S_FIN: begin
                    state <= S_IDLE;
                    if (busy) begin
                        hi   <= iter_acc_lo;
                        lo   <= '1;
                        res  <= '1;
                        zf   <= 1'b0;
                        done <= 1'b1;
                        busy <= 1'b0;
                    end
                end
                default: state <= S_IDLE;
            endcase

            if (accept) begin
                if (sel == SEL_MULTU) begin
                    busy  <= 1'b1;
                    state <= S_MUL;
                end else if (sel == SEL_DIVU) begin
                    busy  <= 1'b1;
                    state <= (op2 == '0) ? S_FIN : S_DIV;
                end else begin
                    res   <= alu_res;
                    zf    <= (alu_res == '0);
                    done  <= 1'b1;
                    state <= S_IDLE;
                end
            end
        end
    end

endmodule

// File: tb/tb_alu_md.sv
// Directed self-checking bench for alu_md at WIDTH=32.
module tb_alu_md;
    import alu_pkg::*;

    localparam int W = 32;

    logic         clk;
    logic         rst;
    logic         start;
    logic [W-1:0] op1;
    logic [W-1:0] op2;
    logic [3:0]   sel;
    logic         busy;
    logic         done;
    logic [W-1:0] res;
    logic         zf;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    state_t       fsm_state;

    int n_vec = 0;
    int n_err = 0;
    logic [W-1:0] exp_q[$];

    alu_md #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .op1       (op1),
        .op2       (op2),
        .sel       (sel),
        .busy      (busy),
        .done      (done),
        .res       (res),
        .zf        (zf),
        .hi        (hi),
        .lo        (lo),
        .fsm_state (fsm_state)
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Drive one request; returns just after the accepting edge
    task automatic op_go(input logic [3:0] s, input logic [W-1:0] a, input logic [W-1:0] b);
        @(negedge clk);
        sel   = s;
        op1   = a;
        op2   = b;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    // Cycles from acceptance until done is seen (0 when it never comes)
    task automatic wait_done(output int lat);
        lat = 0;
        for (int k = 1; k <= 80; k++) begin
            @(negedge clk);
            if (done) begin
                lat = k;
                break;
            end
        end
    endtask

    // Single-cycle op: done one cycle later with res and zf from the expected queue
    task automatic alu_vec(input string tag, input logic [3:0] s,
                           input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic [W-1:0] e);
        logic [W-1:0] want;
        op_go(s, a, b);
        exp_q.push_back(e);
        @(negedge clk);
        want = exp_q.pop_front();
        check({tag, "_done"}, 64'(done), 64'(1));
        check({tag, "_res"}, 64'(res), 64'(want));
        check({tag, "_zf"}, 64'(zf), 64'(want == '0));
    endtask

    // Long op: latency plus final hi/lo/res/zf
    task automatic long_vec(input string tag, input logic [3:0] s,
                            input logic [W-1:0] a, input logic [W-1:0] b,
                            input int lat_e, input logic [W-1:0] hi_e,
                            input logic [W-1:0] lo_e, input logic zf_e);
        int lat;
        op_go(s, a, b);
        wait_done(lat);
        check({tag, "_lat"}, 64'(lat), 64'(lat_e));
        check({tag, "_hi"}, 64'(hi), 64'(hi_e));
        check({tag, "_lo"}, 64'(lo), 64'(lo_e));
        check({tag, "_res"}, 64'(res), 64'(lo_e));
        check({tag, "_zf"}, 64'(zf), 64'(zf_e));
    endtask

    initial begin
        int lat;
        int pulses;
        rst   = 1'b1;
        start = 1'b0;
        sel   = '0;
        op1   = '0;
        op2   = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_done", 64'(done), 64'(0));
        check("rst_res", 64'(res), 64'(0));
        check("rst_zf", 64'(zf), 64'(1));
        check("rst_hi", 64'(hi), 64'(0));
        check("rst_lo", 64'(lo), 64'(0));
        check("rst_state", 64'(fsm_state), 64'(S_IDLE));

        // Single-cycle ops
        alu_vec("add", SEL_ADD, 32'd5, 32'd7, 32'd12);
        @(negedge clk);
        check("add_pulse", 64'(done), 64'(0));
        check("add_hold", 64'(res), 64'(12));
        alu_vec("sub0", SEL_SUB, 32'd9, 32'd9, 32'd0);
        alu_vec("slt", SEL_SLT, 32'hFFFF_FFFF, 32'd1, 32'd1);
        alu_vec("sltu", SEL_SLTU, 32'hFFFF_FFFF, 32'd1, 32'd0);
        alu_vec("slt2", SEL_SLT, 32'h7FFF_FFFF, 32'h8000_0000, 32'd0);
        alu_vec("sltu2", SEL_SLTU, 32'h7FFF_FFFF, 32'h8000_0000, 32'd1);
        alu_vec("and", SEL_AND, 32'hF0F0_1234, 32'h0FF0_FF00, 32'h00F0_1200);
        alu_vec("or", SEL_OR, 32'hF0F0_1234, 32'h0FF0_FF00, 32'hFFF0_FF34);
        alu_vec("xor", SEL_XOR, 32'hF0F0_1234, 32'h0FF0_FF00, 32'hFF00_ED34);
        alu_vec("nor", SEL_NOR, 32'hF0F0_1234, 32'h0FF0_FF00, 32'h000F_00CB);
        alu_vec("addwrap", SEL_ADD, 32'hFFFF_FFFF, 32'd1, 32'd0);
        alu_vec("subwrap", SEL_SUB, 32'd0, 32'd1, 32'hFFFF_FFFF);
        alu_vec("badsel", 4'b0100, 32'd3, 32'd4, 32'd0);

        // MULTU timing: busy for 32 cycles, done in the 33rd
        op_go(SEL_MULTU, 32'hFFFF_FFFF, 32'd2);
        pulses = 0;
        for (int k = 1; k <= 33; k++) begin
            @(negedge clk);
            if (busy !== (k <= 32)) pulses++;
            if (done !== (k == 33)) pulses++;
        end
        check("mul_timing_errs", 64'(pulses), 64'(0));
        check("mul_hi", 64'(hi), 64'(1));
        check("mul_lo", 64'(lo), 64'(32'hFFFF_FFFE));
        check("mul_res", 64'(res), 64'(32'hFFFF_FFFE));
        check("mul_zf", 64'(zf), 64'(0));
        alu_vec("mfhi", SEL_MFHI, 32'd0, 32'd0, 32'd1);
        alu_vec("mflo", SEL_MFLO, 32'd0, 32'd0, 32'hFFFF_FFFE);

        long_vec("mulmax", SEL_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 33,
                 32'hFFFF_FFFE, 32'h0000_0001, 1'b0);
        long_vec("mulzero", SEL_MULTU, 32'd0, 32'd5, 33, 32'd0, 32'd0, 1'b1);
        long_vec("div", SEL_DIVU, 32'd100, 32'd7, 33, 32'd2, 32'd14, 1'b0);
        long_vec("divsmall", SEL_DIVU, 32'd5, 32'd9, 33, 32'd5, 32'd0, 1'b1);
        long_vec("divone", SEL_DIVU, 32'hFFFF_FFFF, 32'd1, 33, 32'd0, 32'hFFFF_FFFF, 1'b0);
        long_vec("div0", SEL_DIVU, 32'd100, 32'd0, 2, 32'd100, 32'hFFFF_FFFF, 1'b0);

        // Start while busy is ignored; exactly one done pulse at cycle 33
        op_go(SEL_MULTU, 32'hFFFF_FFFF, 32'h10);
        pulses = 0;
        lat    = 0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (done) begin
                pulses++;
                if (lat == 0) lat = k;
            end
            if (k == 5) begin
                sel   = SEL_ADD;
                op1   = 32'd1;
                op2   = 32'd1;
                start = 1'b1;
            end
            if (k == 6) start = 1'b0;
        end
        check("ign_pulses", 64'(pulses), 64'(1));
        check("ign_lat", 64'(lat), 64'(33));
        check("ign_res", 64'(res), 64'(32'hFFFF_FFF0));
        check("ign_hi", 64'(hi), 64'(32'hF));
        alu_vec("mfhi2", SEL_MFHI, 32'd0, 32'd0, 32'hF);

        // New request accepted in the done cycle
        op_go(SEL_MULTU, 32'd2, 32'd3);
        wait_done(lat);
        check("b2b_lat", 64'(lat), 64'(33));
        sel   = SEL_ADD;
        op1   = 32'd10;
        op2   = 32'd20;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        @(negedge clk);
        check("b2b_done", 64'(done), 64'(1));
        check("b2b_res", 64'(res), 64'(30));
        check("b2b_lo", 64'(lo), 64'(6));

        // Reset 10 cycles into MULTU aborts it
        op_go(SEL_MULTU, 32'hFFFF_FFFF, 32'd2);
        repeat (10) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("abort_busy", 64'(busy), 64'(0));
        check("abort_hi", 64'(hi), 64'(0));
        check("abort_lo", 64'(lo), 64'(0));
        check("abort_res", 64'(res), 64'(0));
        check("abort_zf", 64'(zf), 64'(1));
        pulses = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (done) pulses++;
        end
        check("abort_nodone", 64'(pulses), 64'(0));

        // Reset wins over a simultaneous start
        alu_vec("pre", SEL_ADD, 32'd1, 32'd2, 32'd3);
        @(negedge clk);
        sel   = SEL_ADD;
        op1   = 32'd4;
        op2   = 32'd4;
        start = 1'b1;
        rst   = 1'b1;
        @(posedge clk);
        #1 begin
            start = 1'b0;
            rst   = 1'b0;
        end
        @(negedge clk);
        check("rstpri_done", 64'(done), 64'(0));
        check("rstpri_res", 64'(res), 64'(0));
        check("rstpri_zf", 64'(zf), 64'(1));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/alu_md.md
ALU_MD -- requirements
Module: alu_md

Interface
REQ-001 SHALL have parameter WIDTH, default 32, datapath width in bits (legal range 8..64).
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port start  input  1  request strobe; accepted only when busy=0.
REQ-005 SHALL have port op1  input  WIDTH  first operand, sampled on acceptance.
REQ-006 SHALL have port op2  input  WIDTH  second operand, sampled on acceptance.
REQ-007 SHALL have port sel  input  4  operation select, sampled on acceptance.
REQ-008 SHALL have port busy  output  1  high from the cycle after acceptance until done.
REQ-009 SHALL have port done  output  1  one-cycle pulse; res, zf, hi and lo valid in that cycle.
REQ-010 SHALL have port res  output  WIDTH  registered result.
REQ-011 SHALL have port zf  output  1  registered zero flag.
REQ-012 SHALL have ports hi, lo  output  WIDTH each  architectural HI/LO registers.

Function
REQ-013 SHALL decode sel: 0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0111 SLTU (unsigned), 1100 NOR, 0011 XOR, 1101 SLT (signed), 1000 MULTU, 1001 DIVU, 1010 MFHI, 1011 MFLO; others give res=0.
REQ-014 SHALL wrap ADD/SUB modulo 2^WIDTH with no overflow flag; SLT/SLTU give res=1 or 0, zero-extended.
REQ-015 SHALL, for single-cycle ops (all except MULTU/DIVU), accepted in cycle N, assert done in cycle N+1 with res updated; busy stays 0.
REQ-016 SHALL implement FSM states IDLE, MUL, DIV, FIN; IDLE->MUL on accepted MULTU, IDLE->DIV on accepted DIVU with op2!=0, IDLE->FIN on accepted DIVU with op2=0, MUL/DIV->FIN when iteration counter reaches WIDTH, FIN->IDLE unconditionally.
REQ-017 SHALL compute MULTU by shift-add, one bit per cycle, WIDTH iterations; done in cycle N+WIDTH+1; {hi,lo}=unsigned 2*WIDTH product; res=lo; zf=1 iff whole product is 0.
REQ-018 SHALL compute DIVU by restoring division, one quotient bit per cycle; done in cycle N+WIDTH+1; lo=quotient, hi=remainder, res=lo, zf=1 iff quotient is 0.
REQ-019 SHALL handle DIVU with op2=0 in 2 cycles (done at N+2): lo=all ones, hi=op1, res=all ones, zf=0.
REQ-020 SHALL ignore start while busy=1; operands, hi, lo, res unchanged.
REQ-021 SHALL change hi/lo only on MULTU/DIVU completion; MFHI/MFLO return the value current at acceptance.
REQ-022 SHALL set zf=(res==0) for all single-cycle ops; res and zf hold between done pulses.
REQ-023 SHALL accept a new start in the same cycle done is asserted.

Reset
REQ-024 SHALL, when rst=1 at a rising edge, force state IDLE, busy=0, done=0, res=0, zf=1, hi=0, lo=0, counter=0.
REQ-025 SHALL abort any in-flight MULTU/DIVU on reset with no done pulse and no hi/lo update.
REQ-026 SHALL give rst priority over start in the same cycle.

Structure
REQ-027 SHALL place sel encodings and the FSM state type in shared package alu_pkg.
REQ-028 SHALL implement the iterative multiply/divide datapath (accumulator, shifter, counter) as sub-module alu_md_iter; the single-cycle logic stays in alu_md.

Verification
REQ-029 SHALL cover: WIDTH=32, ADD 5+7 at cycle N -> done at N+1, res=12, zf=0; SUB 9-9 -> res=0, zf=1.
REQ-030 SHALL cover: SLT op1=0xFFFFFFFF, op2=1 -> res=1; SLTU same operands -> res=0.
REQ-031 SHALL cover: MULTU 0xFFFFFFFF*2 -> busy N+1..N+32, done at N+33, hi=1, lo=0xFFFFFFFE, res=0xFFFFFFFE.
REQ-032 SHALL cover: DIVU 100/7 -> done at N+33, lo=14, hi=2; DIVU 100/0 -> done at N+2, lo=0xFFFFFFFF, hi=100.
REQ-033 SHALL cover: start ADD while MULTU busy -> ignored, single done at N+33; then MFHI -> res=hi next cycle.
REQ-034 SHALL cover: rst asserted 10 cycles into MULTU -> next cycle busy=0, hi=lo=0, no done for 40 cycles.
